// File: rtl/div32x32_seq.sv
// Sequential 32/32 radix-2 restoring divider, one quotient bit per clock, start/busy handshake.
// Define DIV32_SIGNED_EN for two's-complement operands (sign correction applied in FINISH).
module div32x32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    rem;
    logic [W-1:0]    dvd;
    logic [W-1:0]    dsr;
    logic            dz;

    logic [W:0]      trial_c;
    logic [W-1:0]    a_mag_c;
    logic [W-1:0]    b_mag_c;
    logic [W-1:0]    q_out_c;
    logic [W-1:0]    r_out_c;

    // Shifted partial remainder minus divisor; bit W is the borrow/sign.
    assign trial_c = {rem, dvd[W-1]} - {1'b0, dsr};

`ifdef DIV32_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign a_mag_c = a[W-1] ? W'(-a) : a;
    assign b_mag_c = b[W-1] ? W'(-b) : b;
    assign q_out_c = neg_q ? W'(-dvd) : dvd;
    assign r_out_c = neg_r ? W'(-rem) : rem;

    // Signs latched with the operands: quotient truncates toward zero, remainder follows the dividend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= a[W-1] ^ b[W-1];
            neg_r <= a[W-1];
        end
    end
`else
    assign a_mag_c = a;
    assign b_mag_c = b;
    assign q_out_c = dvd;
    assign r_out_c = rem;
`endif

    // Control FSM, datapath iteration and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        dsr  <= b_mag_c;
                        dz   <= (b == '0);
                        if (b != '0) begin
                            rem   <= '0;
                            dvd   <= a_mag_c;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            // Raw dividend kept so the zero-divisor remainder is the original a.
                            dvd   <= a;
                            state <= FINISH;
                        end
                    end
                end
                CALC: begin
                    dvd <= {dvd[W-2:0], ~trial_c[W]};
                    rem <= trial_c[W] ? {rem[W-2:0], dvd[W-1]} : trial_c[W-1:0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= dvd;
                    end else begin
                        quotient  <= q_out_c;
                        remainder <= r_out_c;
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32x32_seq.sv
// Self-checking bench for div32x32_seq: directed steps with a result scoreboard.
// Honours DIV32_SIGNED_EN when the design is built with it.
module tb_div32x32_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last;

    div32x32_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_);
        exp_t m;
        if (tb_ == 32'd0) begin
            m = '{q: 32'hFFFF_FFFF, r: ta, dz: 1'b1};
            return m;
        end
        m.dz = 1'b0;
`ifdef DIV32_SIGNED_EN
        if (ta == 32'h8000_0000 && tb_ == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.r = 32'd0;
        end else begin
            m.q = 32'($signed(ta) / $signed(tb_));
            m.r = 32'($signed(ta) % $signed(tb_));
        end
`else
        m.q = ta / tb_;
        m.r = ta % tb_;
`endif
        return m;
    endfunction

    // Drive start for one cycle at a falling edge; returns one edge later with start low.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit push);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        if (push) sb.push_back(model(ta, tb_));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts falling edges since start was asserted until done, then scores the result.
    task automatic wait_done(input string tag, input int exp_lat, input int cnt0);
        int   n;
        exp_t e;
        n = cnt0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: observed=no done expected=done within 60 cycles", tag);
            return;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard: observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " quotient"}, quotient, e.q);
        chk({tag, " remainder"}, remainder, e.r);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dz});
        last = e;
    endtask

    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_);
        issue(ta, tb_, 1'b1);
        chk({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        wait_done(tag, (tb_ == 32'd0) ? 2 : 34, 1);
    endtask

    initial begin
        bit seen_done;
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run("basic", 32'd100, 32'd7);
        chk("basic q const", quotient, 32'd14);
        chk("basic r const", remainder, 32'd2);
        run("divzero", 32'h1234_5678, 32'd0);
        chk("divzero r const", remainder, 32'h1234_5678);
        run("max_by_one", 32'hFFFF_FFFF, 32'd1);
        run("small", 32'd5, 32'd9);
        chk("small q const", quotient, 32'd0);
        run("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Start during busy is ignored; outputs stay at the previous result meanwhile.
        issue(32'd1000, 32'd3, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore held q", quotient, last.q);
        chk("busy_ignore held r", remainder, last.r);
        wait_done("busy_ignore", 34, 7);
        chk("busy_ignore q const", quotient, 32'd333);
        // Back-to-back: start raised in the done cycle.
        issue(32'd50, 32'd5, 1'b1);
        chk("b2b done_cleared", {31'd0, done}, 32'd0);
        wait_done("b2b", 34, 1);
        chk("b2b q const", quotient, 32'd10);

        // Reset mid-operation clears outputs at once and cancels the result.
        issue(32'd12345, 32'd67, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset quotient", quotient, 32'd0);
        chk("midreset remainder", remainder, 32'd0);
        chk("midreset dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("midreset no_done", {31'd0, seen_done}, 32'd0);
        run("after_reset", 32'd9, 32'd3);
        chk("after_reset q const", quotient, 32'd3);

        for (int i = 0; i < 4; i++) begin
            run("random", $urandom, $urandom_range(1, 32'hFFFF));
        end

`ifdef DIV32_SIGNED_EN
        run("s_neg_dvd", 32'hFFFF_FFF9, 32'd2);
        chk("s_neg_dvd q const", quotient, 32'hFFFF_FFFD);
        chk("s_neg_dvd r const", remainder, 32'hFFFF_FFFF);
        run("s_neg_dsr", 32'd7, 32'hFFFF_FFFE);
        chk("s_neg_dsr q const", quotient, 32'hFFFF_FFFD);
        chk("s_neg_dsr r const", remainder, 32'd1);
        run("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF);
        chk("s_overflow q const", quotient, 32'h8000_0000);
        run("s_divzero", 32'hFFFF_FF00, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Busy and done must never coincide.
    always @(negedge clk) begin
        if (reset && busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap: observed=busy&done expected=exclusive");
        end
    end

endmodule
